// File: rtl/mem_request_queue.sv
// mem_request_queue
//   Initiator side of the execute-to-memory interface. Operations from the
//   execute stage are taken over a valid/ready handshake and held in a small
//   FIFO. One packed 36-bit request word per cycle is registered toward the
//   memory-access stage. When nothing is eligible, an all-zero bubble is sent.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   execute-side handshake (ready = !full, registered only)
//   in_addr          5-bit word address
//   in_value         16-bit data; only [10:0] is carried
//   in_is_load, in_is_mem_write, in_is_write, in_reg  op flags / dest reg
//   mem_stall        memory stage cannot take a request this cycle
//   req_word         registered packed request (36'h0 = bubble)
//   issued_count     count of non-bubble requests issued (wraps)
//   err_illegal      sticky: an op arrived with both load and mem_write set
module mem_request_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_addr,
  input  logic [15:0]      in_value,
  input  logic             in_is_load,
  input  logic             in_is_mem_write,
  input  logic             in_is_write,
  input  logic [2:0]       in_reg,
  input  logic             mem_stall,
  output logic [35:0]      req_word,
  output logic [CNT_W-1:0] issued_count,
  output logic             err_illegal
);

  localparam int AW = $clog2(DEPTH);

  // Low 22 bits of the request word; bits [35:22] are always zero.
  typedef struct packed {
    logic [2:0]  rd;
    logic        wr;
    logic        mw;
    logic        ld;
    logic [10:0] val;
    logic [4:0]  addr;
  } req_t;

  req_t          in_req;
  req_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   cnt;
  logic          empty, full;
  logic          accept, illegal, legal_acc;
  logic          push, pop, bypass;
  req_t          next_req;

  // Upper value bits are intentionally dropped by the packed format.
  logic unused_value_hi;
  assign unused_value_hi = ^in_value[15:11];

  assign in_req = '{rd: in_reg, wr: in_is_write, mw: in_is_mem_write,
                    ld: in_is_load, val: in_value[10:0], addr: in_addr};

  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign in_ready = !full;

  assign accept    = in_valid && in_ready;
  assign illegal   = in_is_load && in_is_mem_write;
  assign legal_acc = accept && !illegal;

  // Bypass only when the queue is empty and the memory side is free, so
  // ordering is never violated. Otherwise a legal op goes into the FIFO.
  assign pop    = !mem_stall && !empty;
  assign bypass = !mem_stall && empty && legal_acc;
  assign push   = legal_acc && !bypass;

  always_comb begin
    next_req = '0;
    if (pop)         next_req = mem[rd_ptr];
    else if (bypass) next_req = in_req;
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt          <= '0;
      req_word     <= '0;
      issued_count <= '0;
      err_illegal  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      req_word <= {14'h0, next_req};
      if (pop || bypass) issued_count <= issued_count + 1'b1;
      if (accept && illegal) err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_request_queue.sv
// tb_mem_request_queue
//   Directed bench for mem_request_queue. Inputs change 1 time unit after a
//   rising edge; outputs are sampled at that same point.
module tb_mem_request_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [15:0] in_value;
  logic        in_is_load, in_is_mem_write, in_is_write;
  logic [2:0]  in_reg;
  logic        mem_stall;
  logic [35:0] req_word;
  logic [15:0] issued_count;
  logic        err_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  mem_request_queue #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_value(in_value),
    .in_is_load(in_is_load), .in_is_mem_write(in_is_mem_write),
    .in_is_write(in_is_write), .in_reg(in_reg),
    .mem_stall(mem_stall),
    .req_word(req_word), .issued_count(issued_count),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] a, input logic [15:0] v, input logic ld,
                        input logic mw, input logic wr, input logic [2:0] r);
    in_valid = 1'b1; in_addr = a; in_value = v;
    in_is_load = ld; in_is_mem_write = mw; in_is_write = wr; in_reg = r;
  endtask

  // Expected request word from the documented field layout.
  function automatic logic [35:0] exp_word(input logic [4:0] a, input logic [15:0] v,
                                           input logic ld, input logic mw,
                                           input logic wr, input logic [2:0] r);
    return {14'h0, r, wr, mw, ld, v[10:0], a};
  endfunction

  logic [35:0] exp_q[$];
  logic [35:0] w;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_value = '0;
    in_is_load = 0; in_is_mem_write = 0; in_is_write = 0; in_reg = '0;
    mem_stall = 1'b0;
    #12;
    chk("rst_ready",  in_ready, 1);
    chk("rst_word",   req_word, 0);
    chk("rst_count",  issued_count, 0);
    chk("rst_err",    err_illegal, 0);
    rst = 1'b0;
    step();

    // Single op bypasses an empty queue in one edge.
    set_op(5'd3, 16'h0155, 0, 0, 1, 3'd5);
    step();
    in_valid = 1'b0;
    chk("single_word",  req_word, 36'h0_002C_2AA3);
    chk("single_count", issued_count, 1);
    step();
    chk("single_bubble", req_word, 0);

    // Back-to-back, one per cycle, no stall.
    for (int i = 0; i < 6; i++) begin
      set_op(5'(i + 8), 16'(i * 16'h0123), 0, i[0], 1, 3'(i));
      chk("b2b_ready", in_ready, 1);
      w = exp_word(5'(i + 8), 16'(i * 16'h0123), 0, i[0], 1, 3'(i));
      step();
      chk("b2b_word", req_word, w);
    end
    in_valid = 1'b0;
    chk("b2b_count", issued_count, 7);
    step();
    chk("b2b_bubble", req_word, 0);

    // Stall fill: 4 accepted, 5th blocked, then in-order drain.
    mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_op(5'(20 + i), 16'h0700 + 16'(i), 1, 0, 1, 3'(7 - i));
      exp_q.push_back(exp_word(5'(20 + i), 16'h0700 + 16'(i), 1, 0, 1, 3'(7 - i)));
      chk("fill_ready", in_ready, (i < 4) ? 1 : 0);
      if (i < 4) begin
        step();
        chk("fill_bubble", req_word, 0);
      end
    end
    step();
    chk("full_bubble", req_word, 0);
    chk("full_ready", in_ready, 0);
    mem_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic took;
      took = in_valid && in_ready;
      step();
      if (took) in_valid = 1'b0;
      chk("drain_word", req_word, exp_q.pop_front());
    end
    in_valid = 1'b0;
    step();
    chk("drain_bubble", req_word, 0);
    chk("drain_count", issued_count, 12);
    chk("drain_ready", in_ready, 1);

    // Illegal op: handshake completes, op dropped, sticky error.
    set_op(5'd9, 16'h1234, 1, 1, 1, 3'd2);
    chk("ill_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("ill_err",   err_illegal, 1);
    chk("ill_word",  req_word, 0);
    chk("ill_count", issued_count, 12);
    repeat (10) step();
    chk("ill_sticky", err_illegal, 1);
    chk("ill_none",   req_word, 0);

    // Value truncation to 11 bits.
    set_op(5'd0, 16'hFFFF, 0, 0, 0, 3'd0);
    step();
    in_valid = 1'b0;
    chk("trunc_val",  req_word[15:5], 11'h7FF);
    chk("trunc_hi",   req_word[35:22], 0);
    chk("trunc_word", req_word, 36'h0_0000_FFE0);
    chk("trunc_count", issued_count, 13);

    // Async reset with three queued ops under stall.
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(5'(i + 1), 16'h0042, 0, 1, 0, 3'd1);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_ready", in_ready, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_word",  req_word, 0);
    chk("arst_count", issued_count, 0);
    chk("arst_err",   err_illegal, 0);
    chk("arst_ready", in_ready, 1);
    #3;
    rst = 1'b0;
    mem_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_word", req_word, 0);
    end
    chk("post_rst_count", issued_count, 0);
    chk("post_rst_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
